// File: rtl/cmp_tally.sv
// cmp_tally: per-frame statistics collector for the 4-bit compare stage.
// Accumulates beat count, flag tallies (saturating) and a running signed
// maximum of the operand, then presents the frame results on a held
// valid/ready output port.
//
// Handshakes: a beat is taken on any rising clk edge where in_valid and
// in_ready are both 1; results are taken on any edge where out_valid and
// out_ready are both 1. Neither ready depends combinationally on its valid.
module cmp_tally #(
    parameter int W  = 4,
    parameter int CW = 8
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [W-1:0]  in_a,
    input  logic          in_gt_u,
    input  logic          in_gt_s,
    input  logic          in_eq,
    input  logic          in_last,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [CW-1:0] out_cnt,
    output logic [CW-1:0] out_gtu,
    output logic [CW-1:0] out_gts,
    output logic [CW-1:0] out_eq,
    output logic [W-1:0]  out_max_s,
    output logic          dbg_state
);

    typedef enum logic {
        ST_ACC  = 1'b0,
        ST_HOLD = 1'b1
    } state_t;

    localparam logic [W-1:0]  MOST_NEG = {1'b1, {(W-1){1'b0}}};
    localparam logic [CW-1:0] CNT_MAX  = {CW{1'b1}};

    state_t        r_state;
    logic          r_in_ready;
    logic          r_out_valid;

    // Working (in-progress) frame tallies
    logic [CW-1:0] r_cnt;
    logic [CW-1:0] r_gtu;
    logic [CW-1:0] r_gts;
    logic [CW-1:0] r_eq;
    logic [W-1:0]  r_max;

    // Held frame results
    logic [CW-1:0] r_out_cnt;
    logic [CW-1:0] r_out_gtu;
    logic [CW-1:0] r_out_gts;
    logic [CW-1:0] r_out_eq;
    logic [W-1:0]  r_out_max;

    logic          w_accept;
    logic [CW-1:0] w_cnt_next;
    logic [CW-1:0] w_gtu_next;
    logic [CW-1:0] w_gts_next;
    logic [CW-1:0] w_eq_next;
    logic [W-1:0]  w_max_next;

    // Increment by en, sticking at all-ones instead of wrapping.
    function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] v, input logic en);
        return (en && (v != CNT_MAX)) ? v + CW'(1) : v;
    endfunction

    // Working values including the current beat (used both to update and to publish).
    always_comb begin
        w_accept   = in_valid & r_in_ready;
        w_cnt_next = sat_inc(r_cnt, 1'b1);
        w_gtu_next = sat_inc(r_gtu, in_gt_u);
        w_gts_next = sat_inc(r_gts, in_gt_s);
        w_eq_next  = sat_inc(r_eq,  in_eq);
        w_max_next = ($signed(in_a) > $signed(r_max)) ? in_a : r_max;
    end

    // FSM, working tallies and registered outputs; reset overrides all events.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= ST_ACC;
            r_in_ready  <= 1'b1;
            r_out_valid <= 1'b0;
            r_cnt       <= '0;
            r_gtu       <= '0;
            r_gts       <= '0;
            r_eq        <= '0;
            r_max       <= MOST_NEG;
            r_out_cnt   <= '0;
            r_out_gtu   <= '0;
            r_out_gts   <= '0;
            r_out_eq    <= '0;
            r_out_max   <= '0;
        end else begin
            case (r_state)
                ST_ACC: begin
                    if (w_accept) begin
                        if (in_last) begin
                            // Publish the frame including this beat, then start fresh.
                            r_out_cnt   <= w_cnt_next;
                            r_out_gtu   <= w_gtu_next;
                            r_out_gts   <= w_gts_next;
                            r_out_eq    <= w_eq_next;
                            r_out_max   <= w_max_next;
                            r_cnt       <= '0;
                            r_gtu       <= '0;
                            r_gts       <= '0;
                            r_eq        <= '0;
                            r_max       <= MOST_NEG;
                            r_state     <= ST_HOLD;
                            r_in_ready  <= 1'b0;
                            r_out_valid <= 1'b1;
                        end else begin
                            r_cnt <= w_cnt_next;
                            r_gtu <= w_gtu_next;
                            r_gts <= w_gts_next;
                            r_eq  <= w_eq_next;
                            r_max <= w_max_next;
                        end
                    end
                end
                ST_HOLD: begin
                    // Input is ignored here; wait for the consumer to take results.
                    if (out_ready) begin
                        r_state     <= ST_ACC;
                        r_in_ready  <= 1'b1;
                        r_out_valid <= 1'b0;
                    end
                end
                default: begin
                    r_state     <= ST_ACC;
                    r_in_ready  <= 1'b1;
                    r_out_valid <= 1'b0;
                end
            endcase
        end
    end

    assign in_ready  = r_in_ready;
    assign out_valid = r_out_valid;
    assign out_cnt   = r_out_cnt;
    assign out_gtu   = r_out_gtu;
    assign out_gts   = r_out_gts;
    assign out_eq    = r_out_eq;
    assign out_max_s = r_out_max;
    assign dbg_state = r_state;

endmodule
